// File: rtl/and_gate_pkg.sv
// Shared constants for the and_gate block and its bench.
package and_gate_pkg;

  // Default operand width for A, B, Y and Y_R.
  localparam int unsigned DEFAULT_WIDTH = 1;

  // Default width of the saturating rise counter.
  localparam int unsigned DEFAULT_CNT_W = 8;

endpackage : and_gate_pkg

// File: rtl/and_gate_edge_counter.sv
// Rising-edge detector on a single bit plus a saturating pulse counter.
module edge_counter
  import and_gate_pkg::*;
#(
  parameter int unsigned CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             d,
  output logic             pulse,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             d_prev;
  logic             pulse_nxt;
  logic [CNT_W-1:0] count_nxt;

  // Next-state: pulse when d is high now but was low last cycle; count holds at max.
  always_comb begin
    pulse_nxt = 1'b0;
    count_nxt = count;
    pulse_nxt = d & ~d_prev;
    if (pulse && (count != CNT_MAX)) begin
      count_nxt = count + CNT_W'(1);
    end
  end

  // State registers; synchronous reset overrides any pending pulse or increment.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      d_prev <= 1'b0;
      pulse  <= 1'b0;
      count  <= '0;
    end else begin
      d_prev <= d;
      pulse  <= pulse_nxt;
      count  <= count_nxt;
    end
  end

endmodule : edge_counter

// File: rtl/and_gate.sv
// Bitwise AND with a registered copy and a rise counter on bit 0 of the copy.
module and_gate
  import and_gate_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] Y_R,
  output logic             Y_RISE,
  output logic [CNT_W-1:0] RISE_CNT
);

  // Zero-latency AND, independent of clock and reset.
  assign Y = A & B;

  // One-cycle registered copy of Y.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      Y_R <= '0;
    end else begin
      Y_R <= Y;
    end
  end

  // Rise detection and counting on the registered LSB only, so sub-cycle glitches are ignored.
  edge_counter #(
    .CNT_W (CNT_W)
  ) u_edge_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (Y_R[0]),
    .pulse (Y_RISE),
    .count (RISE_CNT)
  );

endmodule : and_gate

// File: tb/tb_and_gate.sv
// Directed bench for and_gate: default, 4-bit and 2-bit-counter instances.
module tb_and_gate;
  import and_gate_pkg::*;

  localparam int unsigned W  = DEFAULT_WIDTH;
  localparam int unsigned CW = DEFAULT_CNT_W;

  logic clk = 1'b0;
  logic clk_run = 1'b0;
  logic rst_n = 1'b1;

  logic [W-1:0]  a, b, y, y_r;
  logic          rise;
  logic [CW-1:0] cnt;

  logic [3:0] a4, b4, y4, y4_r;
  logic       rise4;
  logic [CW-1:0] cnt4;

  logic       a2, b2, y2, y2_r, rise2;
  logic [1:0] cnt2;

  int checks = 0;
  int errors = 0;

  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  and_gate u_dut (
    .clk(clk), .rst_n(rst_n), .A(a), .B(b),
    .Y(y), .Y_R(y_r), .Y_RISE(rise), .RISE_CNT(cnt)
  );

  and_gate #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst_n(rst_n), .A(a4), .B(b4),
    .Y(y4), .Y_R(y4_r), .Y_RISE(rise4), .RISE_CNT(cnt4)
  );

  and_gate #(.CNT_W(2)) u_c2 (
    .clk(clk), .rst_n(rst_n), .A(a2), .B(b2),
    .Y(y2), .Y_R(y2_r), .Y_RISE(rise2), .RISE_CNT(cnt2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic xb;
    logic y_exp_x;
    int   exp2;

    a = '0; b = '0; a4 = '0; b4 = '0; a2 = 1'b0; b2 = 1'b0;

    // Truth table with clock idle
    #10; check("tt_00", 32'(y), 32'd0);
    b = 1'b1; #10; check("tt_01", 32'(y), 32'd0);
    a = 1'b1; b = 1'b0; #10; check("tt_10", 32'(y), 32'd0);
    b = 1'b1; #10; check("tt_11", 32'(y), 32'd1);

    // Unknown operand: 1 & X follows '&', 0 & X is 0
    xb = 1'bx;
    y_exp_x = 1'b1 & xb;
    a = 1'b1; b = xb; #1; check("x_a1", 32'(y), 32'(y_exp_x));
    a = 1'b0; #1;        check("x_a0", 32'(y), 32'd0);

    // 4-bit combinational result
    a4 = 4'b1100; b4 = 4'b1010; #1;
    check("w4_y", 32'(y4), 32'h8);

    // Reset with clock running
    a = 1'b0; b = 1'b0; rst_n = 1'b0; clk_run = 1'b1;
    step(); step();
    check("rst_y_r", 32'(y_r), 32'd0);
    check("rst_rise", 32'(rise), 32'd0);
    check("rst_cnt", 32'(cnt), 32'd0);
    check("rst_w4_y_r", 32'(y4_r), 32'd0);
    check("rst_c2_cnt", 32'(cnt2), 32'd0);
    a = 1'b1; b = 1'b1; #1;
    check("rst_y_comb", 32'(y), 32'd1);

    // Release, A=B=1 held for 5 edges
    rst_n = 1'b1;
    step();
    check("hold1_y_r", 32'(y_r), 32'd1);
    check("hold1_rise", 32'(rise), 32'd0);
    check("hold1_w4_y_r", 32'(y4_r), 32'h8);
    step();
    check("hold2_rise", 32'(rise), 32'd1);
    check("hold2_cnt", 32'(cnt), 32'd0);
    step();
    check("hold3_rise", 32'(rise), 32'd0);
    check("hold3_cnt", 32'(cnt), 32'd1);
    step(); step();
    check("hold5_rise", 32'(rise), 32'd0);
    check("hold5_cnt", 32'(cnt), 32'd1);

    // Sub-cycle glitch on Y is not captured
    a = 1'b0;
    step(); step();
    check("gl_pre_y_r", 32'(y_r), 32'd0);
    a = 1'b1; #2; a = 1'b0;
    step();
    check("gl_y_r", 32'(y_r), 32'd0);
    step();
    check("gl_rise", 32'(rise), 32'd0);
    check("gl_cnt", 32'(cnt), 32'd1);

    // Reset beats a pending increment
    a = 1'b1;
    step();
    check("pend_y_r", 32'(y_r), 32'd1);
    step();
    check("pend_rise", 32'(rise), 32'd1);
    rst_n = 1'b0;
    step();
    check("pend_rst_cnt", 32'(cnt), 32'd0);
    check("pend_rst_rise", 32'(rise), 32'd0);
    check("pend_rst_y_r", 32'(y_r), 32'd0);

    // Reset in the cycle Y_R[0] rises suppresses the pulse
    rst_n = 1'b1;
    step();
    check("coll_y_r", 32'(y_r), 32'd1);
    check("coll_rise_pre", 32'(rise), 32'd0);
    rst_n = 1'b0;
    step();
    check("coll_rise", 32'(rise), 32'd0);
    check("coll_cnt", 32'(cnt), 32'd0);
    a = 1'b0; rst_n = 1'b1;
    step(); step();
    check("coll_after_rise", 32'(rise), 32'd0);
    check("coll_after_cnt", 32'(cnt), 32'd0);

    // 2-bit counter saturates at 3
    for (int i = 0; i < 5; i++) begin
      a2 = 1'b1; b2 = 1'b1;
      step(); step();
      a2 = 1'b0; b2 = 1'b0;
      step(); step();
      exp2 = (i + 1 > 3) ? 3 : i + 1;
      check($sformatf("sat_cnt_%0d", i), 32'(cnt2), 32'(exp2));
    end
    check("sat_rise_idle", 32'(rise2), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_and_gate

// File: doc/and_gate.md
AND_GATE -- requirements
Module: and_gate

Interface
REQ-001 Parameter WIDTH, default 1: bit width of A, B, Y and Y_R.
REQ-002 Parameter CNT_W, default 8: width of RISE_CNT.
REQ-003 clk  input  1  single clock; every register updates on its rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset, sampled on the clk rising edge.
REQ-005 A  input  WIDTH  operand A.
REQ-006 B  input  WIDTH  operand B.
REQ-007 Y  output  WIDTH  combinational bitwise AND of A and B.
REQ-008 Y_R  output  WIDTH  registered copy of Y.
REQ-009 Y_RISE  output  1  one-cycle pulse on a rising edge of Y_R[0].
REQ-010 RISE_CNT  output  CNT_W  saturating count of Y_RISE pulses.

Function
REQ-011 Y SHALL equal A & B bit by bit at all times, with zero clock latency and no dependence on clk or rst_n.
REQ-012 Truth table per bit SHALL be: 0,0->0; 0,1->0; 1,0->0; 1,1->1.
REQ-013 An X or Z on any input bit SHALL follow Verilog "&" semantics: 0 dominates, otherwise X.
REQ-014 Y_R SHALL take the value of Y sampled at each clk rising edge, giving exactly one cycle of latency.
REQ-015 Y_RISE SHALL be 1 for exactly one cycle when Y_R[0] goes from 0 to 1 between consecutive edges; otherwise it SHALL be 0.
REQ-016 Y_RISE SHALL be registered and asserted in the cycle after Y_R[0] first reads 1.
REQ-017 RISE_CNT SHALL increment by 1 on each cycle in which Y_RISE is 1.
REQ-018 RISE_CNT SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap to 0.
REQ-019 A Y pulse shorter than one clk period between two edges SHALL NOT affect Y_R, Y_RISE or RISE_CNT.
REQ-020 Y held at 1 for many cycles SHALL produce exactly one Y_RISE pulse.

Reset
REQ-021 When rst_n=0 at a clk rising edge, the next state SHALL be: Y_R=0, Y_RISE=0, RISE_CNT=0, and the internal previous-Y_R[0] flag=0.
REQ-022 Reset SHALL take priority over every update in the same cycle, including a pending increment.
REQ-023 Reset SHALL NOT affect Y, which remains combinational.
REQ-024 After rst_n returns to 1, a Y_R[0] that is already 1 SHALL generate one Y_RISE pulse, because the previous-value flag is 0.
REQ-025 Before the first reset edge, register outputs SHALL be don't-care.

Structure
REQ-026 The default WIDTH and CNT_W values SHALL live in a shared constants header included by and_gate and its bench.
REQ-027 The rise detector plus saturating counter SHALL be one sub-module, edge_counter (ports clk, rst_n, d, pulse, count).
REQ-028 and_gate SHALL instantiate edge_counter once, driven by Y_R[0].
REQ-029 The combinational AND SHALL be a continuous assignment with no latch.

Verification
REQ-030 Scenario: A,B stepped 00,01,10,11 every 10 ns, clk idle -> Y = 0,0,0,1.
REQ-031 Scenario: reset, then A=B=1 held 5 cycles -> Y_R=1 from the first edge, one Y_RISE pulse, RISE_CNT=1.
REQ-032 Scenario: CNT_W=2, 5 separate 0->1 transitions of Y -> RISE_CNT=1,2,3,3,3.
REQ-033 Scenario: rst_n=0 in the same cycle as a rising edge of Y_R[0] -> RISE_CNT stays 0 and Y_RISE stays 0.
REQ-034 Scenario: WIDTH=4, A=4'b1100, B=4'b1010 -> Y=4'b1000 immediately, Y_R=4'b1000 one edge later.
REQ-035 Scenario: A=1, B=X -> Y=X; A=0, B=X -> Y=0.
